// File: rtl/memory_arbiter_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : memory_arbiter_ctrl                                        |
// | Description : Serialises instruction-fetch and data requests onto one    |
// |               single-ported RAM. Data wins arbitration unless the last   |
// |               grant was data and a fetch is waiting. Each access is      |
// |               held stable until ram_ready_i. A watchdog latches a        |
// |               sticky error if an access hangs.                           |
// | Ports       : clk_i/rst_i      clock, async active-high reset            |
// |               iren_i/iaddr_i   fetch request -> iload_o/ihit_o           |
// |               dren_i/dwen_i    data request (daddr_i/dstore_i)           |
// |                                -> dload_o/dhit_o                         |
// |               ram_*_o          registered RAM strobes/address/data       |
// |               ram_load_i       RAM read data                             |
// |               ram_ready_i      RAM access done this cycle                |
// |               err_o            sticky watchdog timeout                   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module memory_arbiter_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              iren_i,
   input  logic [ADDR_W-1:0] iaddr_i,
   output logic [DATA_W-1:0] iload_o,
   output logic              ihit_o,
   input  logic              dren_i,
   input  logic              dwen_i,
   input  logic [ADDR_W-1:0] daddr_i,
   input  logic [DATA_W-1:0] dstore_i,
   output logic [DATA_W-1:0] dload_o,
   output logic              dhit_o,
   output logic              ram_ren_o,
   output logic              ram_wen_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [DATA_W-1:0] ram_store_o,
   input  logic [DATA_W-1:0] ram_load_i,
   input  logic              ram_ready_i,
   output logic              err_o
);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_DATA  = 2'd1;
   localparam logic [1:0] c_INSTR = 2'd2;
   localparam logic [1:0] c_ERR   = 2'd3;

   // Counter must hold values up to TIMEOUT-1; keep at least one bit.
   localparam int            c_WD_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   logic [1:0]        state_q, state_d;
   logic              ram_ren_q, ram_ren_d;
   logic              ram_wen_q, ram_wen_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_store_q, ram_store_d;
   logic              last_data_q, last_data_d;   // 1: last grant went to data
   logic [c_WD_W-1:0] wdog_q, wdog_d;
   logic              err_q, err_d;

   logic w_dreq;
   logic w_dhit;
   logic w_ihit;

   assign w_dreq = dren_i | dwen_i;

   // Hits need the request still asserted; a requester that withdrew
   // mid-access gets no strobe although the RAM access itself completes.
   assign w_dhit = (state_q == c_DATA)  && ram_ready_i && w_dreq;
   assign w_ihit = (state_q == c_INSTR) && ram_ready_i && iren_i;

   always_comb begin
      state_d     = state_q;
      ram_ren_d   = ram_ren_q;
      ram_wen_d   = ram_wen_q;
      ram_addr_d  = ram_addr_q;
      ram_store_d = ram_store_q;
      last_data_d = last_data_q;
      wdog_d      = wdog_q;
      err_d       = err_q;
      case (state_q)
         c_IDLE: begin
            wdog_d = '0;
            // Alternation: a waiting fetch beats data right after a data grant.
            if (w_dreq && !(last_data_q && iren_i)) begin
               state_d     = c_DATA;
               ram_ren_d   = ~dwen_i;   // read+write together is a write
               ram_wen_d   = dwen_i;
               ram_addr_d  = daddr_i;
               ram_store_d = dstore_i;
               last_data_d = 1'b1;
            end else if (iren_i) begin
               state_d     = c_INSTR;
               ram_ren_d   = 1'b1;
               ram_wen_d   = 1'b0;
               ram_addr_d  = iaddr_i;
               ram_store_d = '0;
               last_data_d = 1'b0;
            end
         end
         c_DATA, c_INSTR: begin
            if (ram_ready_i) begin
               state_d   = c_IDLE;
               ram_ren_d = 1'b0;
               ram_wen_d = 1'b0;
            end else if ((TIMEOUT != 0) && (wdog_q == c_WD_LAST)) begin
               state_d   = c_ERR;
               ram_ren_d = 1'b0;
               ram_wen_d = 1'b0;
               err_d     = 1'b1;
            end else if (TIMEOUT != 0) begin
               wdog_d = wdog_q + c_WD_W'(1);
            end
         end
         default: begin
            // Error state is terminal until reset.
            ram_ren_d = 1'b0;
            ram_wen_d = 1'b0;
            err_d     = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= c_IDLE;
         ram_ren_q   <= 1'b0;
         ram_wen_q   <= 1'b0;
         ram_addr_q  <= '0;
         ram_store_q <= '0;
         last_data_q <= 1'b0;
         wdog_q      <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ram_ren_q   <= ram_ren_d;
         ram_wen_q   <= ram_wen_d;
         ram_addr_q  <= ram_addr_d;
         ram_store_q <= ram_store_d;
         last_data_q <= last_data_d;
         wdog_q      <= wdog_d;
         err_q       <= err_d;
      end
   end

   assign ihit_o      = w_ihit;
   assign dhit_o      = w_dhit;
   assign iload_o     = w_ihit ? ram_load_i : '0;
   assign dload_o     = (w_dhit && !ram_wen_q) ? ram_load_i : '0;
   assign ram_ren_o   = ram_ren_q;
   assign ram_wen_o   = ram_wen_q;
   assign ram_addr_o  = ram_addr_q;
   assign ram_store_o = ram_store_q;
   assign err_o       = err_q;

endmodule
`default_nettype wire
